// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with a one-entry holding register.
// Frame: start, DATA_BITS data (LSB first), optional parity, one stop bit.
//
// Ports:
//   i_Clock      system clock
//   i_reset      asynchronous active-low reset
//   i_tick       one-cycle oversampling strobe from the baud generator
//   i_rx         asynchronous serial input, idle high
//   i_rd         host read strobe, consumes the held byte
//   o_data       received byte, right-justified
//   o_valid      o_data holds an unread byte
//   o_frame_err  stop bit of the held byte sampled low
//   o_parity_err parity mismatch on the held byte
//   o_overrun    a frame completed while o_valid was set (sticky)
//   o_busy       receiver is inside a frame
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 i_Clock,
    input  logic                 i_reset,
    input  logic                 i_tick,
    input  logic                 i_rx,
    input  logic                 i_rd,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_overrun,
    output logic                 o_busy
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int NW = $clog2(DATA_BITS);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state_q, state_d;
    logic [SW-1:0]         s_cnt_q, s_cnt_d;
    logic [NW-1:0]         n_cnt_q, n_cnt_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  par_bad_q, par_bad_d;
    logic                  done;
    logic                  rx_m, rx_s;

    // Synchroniser resets to idle level so a low line in reset is no start.
    always_ff @(posedge i_Clock or negedge i_reset) begin
        if (!i_reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= i_rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge i_Clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= IDLE;
            s_cnt_q   <= '0;
            n_cnt_q   <= '0;
            shift_q   <= '0;
            par_bad_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_cnt_q   <= s_cnt_d;
            n_cnt_q   <= n_cnt_d;
            shift_q   <= shift_d;
            par_bad_q <= par_bad_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        s_cnt_d   = s_cnt_q;
        n_cnt_d   = n_cnt_q;
        shift_d   = shift_q;
        par_bad_d = par_bad_q;
        done      = 1'b0;
        if (i_tick) begin
            unique case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d = START;
                        s_cnt_d = '0;
                    end
                end
                START: begin
                    if (s_cnt_q == S_MID) begin
                        // High at mid start bit is a glitch: drop silently.
                        if (!rx_s) begin
                            state_d = DATA;
                            s_cnt_d = '0;
                            n_cnt_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (s_cnt_q == S_LAST) begin
                        s_cnt_d = '0;
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        if (n_cnt_q == N_LAST) begin
                            state_d = PARITY_EN ? PARITY : STOP;
                        end else begin
                            n_cnt_d = n_cnt_q + 1'b1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
                PARITY: begin
                    if (s_cnt_q == S_LAST) begin
                        par_bad_d = (^shift_q) ^ rx_s ^ PARITY_ODD;
                        s_cnt_d   = '0;
                        state_d   = STOP;
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (s_cnt_q == S_LAST) begin
                        done    = 1'b1;
                        s_cnt_d = '0;
                        state_d = IDLE;
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Holding register: a completing frame beats a same-cycle read.
    always_ff @(posedge i_Clock or negedge i_reset) begin
        if (!i_reset) begin
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_frame_err  <= 1'b0;
            o_parity_err <= 1'b0;
            o_overrun    <= 1'b0;
        end else if (done) begin
            if (!o_valid || i_rd) begin
                o_data       <= shift_q;
                o_valid      <= 1'b1;
                o_frame_err  <= ~rx_s;
                o_parity_err <= PARITY_EN && par_bad_q;
                o_overrun    <= 1'b0;
            end else begin
                o_overrun <= 1'b1;
            end
        end else if (i_rd && o_valid) begin
            o_valid      <= 1'b0;
            o_frame_err  <= 1'b0;
            o_parity_err <= 1'b0;
            o_overrun    <= 1'b0;
        end
    end

    assign o_busy = (state_q != IDLE);

endmodule
